// File: rtl/hisoc_loader_pkg.sv
// Shared loader definitions: FSM encoding, header/word geometry and the packed-word record.
package hisoc_loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} ldr_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 8 * HDR_BYTES;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef struct packed {
    logic              vld;
    logic [WORD_W-1:0] data;
  } word_t;

endpackage

// File: rtl/inst_word_packer.sv
// Little-endian byte-to-word packer; emits a one-cycle word_valid after the last byte of a word.
module inst_word_packer
  import hisoc_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       byte_en,
  input  logic [7:0] byte_in,
  output logic       fill,
  output word_t      word
);

  logic [1:0]        bcnt;
  logic [WORD_W-1:0] sr;
  logic              word_valid;

  // fill marks the accept that completes a word; the loader latches the address off it
  assign fill      = byte_en && (bcnt == 2'(BYTES_PER_WORD - 1));
  assign word.vld  = word_valid;
  assign word.data = sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= fill;
      if (clr) begin
        bcnt <= '0;
      end else if (byte_en) begin
        sr   <= {byte_in, sr[WORD_W-1:8]};
        bcnt <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Byte-stream instruction loader: header word count, little-endian word writes, idle timeout.
module inst_loader
  import hisoc_loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1023
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDLE_W    = $clog2(TIMEOUT + 1);
  localparam int MAX_WORDS = 1 << ADDR_W;

  ldr_state_t        state;
  logic [7:0]        cnt_lo;
  logic [HDR_W-1:0]  wcount;
  logic [HDR_W-1:0]  hdr_count;
  logic [ADDR_W:0]   widx;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept, fill, idle_exp, pack_clr, last_wr;
  word_t             word;

  assign s_ready     = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign busy        = s_ready;
  assign done        = (state == DONE);
  assign err         = (state == ERR);
  assign core_enable = done;
  assign mem_we      = word.vld;
  assign mem_wdata   = word.data;

  assign accept    = s_valid && s_ready;
  assign hdr_count = {s_data, cnt_lo};
  assign idle_exp  = !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign pack_clr  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  // widx has already advanced past the word being written
  assign last_wr   = word.vld && (widx == wcount[ADDR_W:0]);

  inst_word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pack_clr),
    .byte_en (accept && (state == DATA)),
    .byte_in (s_data),
    .fill    (fill),
    .word    (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_lo   <= '0;
      wcount   <= '0;
      widx     <= '0;
      idle_cnt <= '0;
      mem_addr <= '0;
    end else begin
      if (fill) begin
        mem_addr <= widx[ADDR_W-1:0];
        widx     <= widx + 1'b1;
      end
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR0;
            widx     <= '0;
            idle_cnt <= '0;
          end
        end
        HDR0: begin
          if (accept) begin
            cnt_lo   <= s_data;
            idle_cnt <= '0;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            idle_cnt <= '0;
            wcount   <= hdr_count;
            if (hdr_count == '0)                  state <= DONE;
            else if (32'(hdr_count) > MAX_WORDS) state <= ERR;
            else                                  state <= DATA;
          end else if (idle_exp) begin
            state <= ERR;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DATA: begin
          if (last_wr)       state    <= DONE;
          else if (accept)   idle_cnt <= '0;
          else if (idle_exp) state    <= ERR;
          else               idle_cnt <= idle_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a queue-based write model.
module tb_inst_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst_n, start, s_valid;
  logic [7:0]        s_data;
  logic              s_ready, mem_we, core_enable, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_we_cyc = -1;
  int   done_rise = -1;
  int   model_addr = 0;
  logic done_q = 1'b0;
  logic rnd_start = 1'b0;
  logic [7:0] rbytes[1024];

  inst_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_enable(core_enable), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // every-cycle compare against the expected write sequence
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      model_addr = 0;
      done_q     = 1'b0;
    end else begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("we_addr", 64'(mem_addr), 64'(e.addr));
          chk("we_data", 64'(mem_wdata), 64'(e.data));
          model_addr = e.addr;
        end
        last_we_cyc = cyc;
      end else begin
        chk("addr_hold", 64'(mem_addr), 64'(model_addr));
      end
      chk("core_en_vs_done", 64'(core_enable), 64'(done));
      chk("busy_vs_ready", 64'(busy), 64'(s_ready));
      if (done && !done_q) done_rise = cyc;
      done_q = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic r;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (rnd_start && $urandom_range(0, 3) == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 100);
    if (!r) chk("byte_accept_bound", 0, 1);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) chk("end_bound", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 0);
    chk({tag, "_mem_we"}, 64'(mem_we), 0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
    chk({tag, "_core_en"}, 64'(core_enable), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
  endtask

  initial begin
    logic [7:0] seq_a[8];
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // two-word load with s_valid held high
    seq_a = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
    exp_q.push_back('{0, 32'h0000_0013});
    exp_q.push_back('{1, 32'h0000_00B3});
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    foreach (seq_a[i]) send_byte(seq_a[i], 0);
    s_valid = 1'b0;
    wait_end();
    chk("a_done", 64'(done), 1);
    chk("a_core_en", 64'(core_enable), 1);
    chk("a_err", 64'(err), 0);
    chk("a_writes_left", 64'(exp_q.size()), 0);
    chk("a_done_latency", 64'(done_rise), 64'(last_we_cyc + 1));

    // zero-length image goes straight to DONE
    pulse_start();
    chk("b_busy", 64'(busy), 1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    s_valid = 1'b0;
    chk("b_done", 64'(done), 1);
    chk("b_core_en", 64'(core_enable), 1);
    @(posedge clk); #1;
    chk("b_writes_left", 64'(exp_q.size()), 0);

    // oversize count 1025
    pulse_start();
    chk("c_core_en_drop", 64'(core_enable), 0);
    send_byte(8'h01, 1);
    send_byte(8'h04, 2);
    s_valid = 1'b0;
    chk("c_err", 64'(err), 1);
    chk("c_core_en", 64'(core_enable), 0);
    chk("c_s_ready", 64'(s_ready), 0);

    // idle timeout mid-word
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    s_valid = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    chk("d_err_early", 64'(err), 0);
    chk("d_busy_early", 64'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk("d_err", 64'(err), 1);
    chk("d_s_ready", 64'(s_ready), 0);
    chk("d_core_en", 64'(core_enable), 0);
    @(posedge clk); #1;
    chk("d_writes_left", 64'(exp_q.size()), 0);

    // 256 random words with random gaps and stray start pulses
    for (int i = 0; i < 1024; i++) rbytes[i] = 8'($urandom);
    for (int w = 0; w < 256; w++)
      exp_q.push_back('{w, {rbytes[4*w+3], rbytes[4*w+2], rbytes[4*w+1], rbytes[4*w]}});
    pulse_start();
    rnd_start = 1'b1;
    send_byte(8'h00, $urandom_range(0, 4));
    send_byte(8'h01, $urandom_range(0, 4));
    for (int i = 0; i < 1024; i++) send_byte(rbytes[i], $urandom_range(0, 4));
    s_valid = 1'b0;
    rnd_start = 1'b0;
    wait_end();
    chk("e_done", 64'(done), 1);
    chk("e_err", 64'(err), 0);
    chk("e_writes_left", 64'(exp_q.size()), 0);

    // reset mid-word, then a fresh one-word load
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("f_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("f_idle_after_rst", 64'(busy | done | err), 0);
    exp_q.push_back('{0, 32'h4433_2211});
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    send_byte(8'h33, 2);
    send_byte(8'h44, 0);
    s_valid = 1'b0;
    wait_end();
    chk("f_done", 64'(done), 1);
    chk("f_writes_left", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width of the instruction memory write port.
REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum idle cycles between accepted bytes during a load.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins a load session.
REQ-006 SHALL have port s_valid  input  1  byte-stream valid.
REQ-007 SHALL have port s_data  input  8  byte-stream data.
REQ-008 SHALL have port s_ready  output  1  byte-stream ready.
REQ-009 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  instruction memory word address.
REQ-011 SHALL have port mem_wdata  output  32  instruction word.
REQ-012 SHALL have port core_enable  output  1  core run enable; drives the core enable input.
REQ-013 SHALL have ports busy, done and err  output  1 each  status flags.

Function
REQ-014 SHALL implement the FSM states IDLE, HDR0, HDR1, DATA, DONE, ERR.
REQ-015 SHALL count a byte as accepted only in a cycle where s_valid and s_ready are both 1; s_ready SHALL be 1 only in HDR0, HDR1 and DATA.
REQ-016 SHALL move from IDLE, DONE or ERR to HDR0 on start, clearing the word index, byte counter and idle counter.
REQ-017 SHALL ignore start while in HDR0, HDR1 or DATA.
REQ-018 SHALL take the header word count little-endian: the HDR0 byte gives count[7:0], then the HDR1 byte gives count[15:8].
REQ-019 SHALL go from HDR1 to DONE when count==0, to ERR when count>2^ADDR_W, and to DATA otherwise.
REQ-020 SHALL pack DATA bytes little-endian: first byte to bits [7:0], fourth byte to bits [31:24].
REQ-021 SHALL assert mem_we for exactly one cycle, the cycle after the fourth byte of a word is accepted, with mem_addr equal to the word index (starting at 0) and mem_wdata equal to the packed word.
REQ-022 SHALL increment the word index after each write; mem_addr SHALL hold its last value when mem_we is 0.
REQ-023 SHALL enter DONE in the cycle after the mem_we pulse for word count-1.
REQ-024 SHALL keep s_ready at 1 during that mem_we cycle, with no bubble.
REQ-025 SHALL increment an idle counter in HDR1 and DATA on every cycle with no accepted byte, and reset it on each accepted byte.
REQ-026 SHALL go to ERR when the idle counter reaches TIMEOUT; HDR0 SHALL have no timeout.
REQ-027 SHALL set busy=1 in HDR0, HDR1 and DATA; done=1 only in DONE; err=1 only in ERR.
REQ-028 SHALL set core_enable=1 only in DONE; it SHALL drop in the same cycle the FSM leaves DONE.
REQ-029 SHALL discard a partial word (1-3 bytes) and issue no write for it on an abort to ERR.

Reset
REQ-030 SHALL force the state to IDLE immediately on rst_n=0, asynchronously.
REQ-031 SHALL drive all outputs to 0 during reset: s_ready, mem_we, mem_addr, mem_wdata, core_enable, busy, done, err.
REQ-032 SHALL abort any session when reset is asserted mid-load; words already written stay in memory; no mem_we pulse SHALL follow release of reset.

Structure
REQ-033 SHALL take the state encodings, HDR_BYTES=2 and BYTES_PER_WORD=4 from shared package hisoc_loader_pkg.
REQ-034 SHALL place byte-to-word packing in one sub-module, inst_word_packer, containing the 2-bit byte counter, the 32-bit shift register and the word_valid pulse.
REQ-035 SHALL keep the FSM, the word index and the idle counter in inst_loader.

Verification
REQ-036 SHALL cover: start, header 02 00, bytes 13 00 00 00 B3 00 00 00 with s_valid held high -> two mem_we pulses: addr 0 data 0x00000013, addr 1 data 0x000000B3; done=1 and core_enable=1 one cycle after the second pulse.
REQ-037 SHALL cover: header 00 00 -> DONE directly after HDR1, no mem_we, core_enable=1.
REQ-038 SHALL cover: header 01 04 (count 1025, ADDR_W=10) -> err=1, no writes, core_enable=0.
REQ-039 SHALL cover: header 01 00, then two bytes, then s_valid low for TIMEOUT cycles -> err=1, no mem_we, s_ready=0.
REQ-040 SHALL cover: random s_valid gaps below TIMEOUT over 256 words -> written words match the reference byte file in order; start pulses during busy have no effect.
REQ-041 SHALL cover: rst_n pulsed low mid-word during DATA -> all outputs 0 immediately; a fresh start with header 01 00 and one word writes addr 0.
